// File: rtl/urng_taus_pair.sv
// urng_taus_pair: two taus88 generators packed into a 48/16-bit uniform pair
// behind a valid/ready output register, with seed loading and warm-up.
`default_nettype none

module urng_taus_pair #(
  parameter int WARMUP = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed_we,
  input  logic [2:0]  seed_sel,
  input  logic [31:0] seed_data,
  input  logic        start,
  input  logic        stop,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [47:0] u0,
  output logic [15:0] u1
);

  localparam int CW = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);

  // Generator state is packed {s3, s2, s1}.
  localparam logic [95:0] A_RST = {32'h0000_D431, 32'h0001_0932, 32'h0000_3039};
  localparam logic [95:0] B_RST = {32'h0F1E_2D3C, 32'h9ABC_DEF0, 32'h1234_5678};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WARM = 2'd1,
    RUN  = 2'd2
  } state_e;

  function automatic logic [95:0] taus_next(input logic [95:0] s);
    logic [31:0] s1, s2, s3, b;
    s1 = s[31:0];
    s2 = s[63:32];
    s3 = s[95:64];
    b  = ((s1 << 13) ^ s1) >> 19;
    s1 = ((s1 & ~32'h1) << 12) ^ b;
    b  = ((s2 << 2) ^ s2) >> 25;
    s2 = ((s2 & ~32'h7) << 4) ^ b;
    b  = ((s3 << 3) ^ s3) >> 11;
    s3 = ((s3 & ~32'hF) << 17) ^ b;
    return {s3, s2, s1};
  endfunction

  // Seeds under a component's minimum would lock it at zero; lift them instead.
  function automatic logic [31:0] seed_fix(input logic [1:0] k, input logic [31:0] d);
    logic [31:0] m;
    m = (k == 2'd0) ? 32'd2 : (k == 2'd1) ? 32'd8 : 32'd16;
    return (d < m) ? d + m : d;
  endfunction

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [95:0]     ga_q, ga_d, gb_q, gb_d;
  logic            valid_q, valid_d;
  logic [47:0]     u0_q, u0_d;
  logic [15:0]     u1_q, u1_d;

  logic [95:0]     ga_n, gb_n;
  logic [31:0]     wa, wb;

  assign ga_n = taus_next(ga_q);
  assign gb_n = taus_next(gb_q);
  assign wa   = ga_n[31:0] ^ ga_n[63:32] ^ ga_n[95:64];
  assign wb   = gb_n[31:0] ^ gb_n[63:32] ^ gb_n[95:64];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ga_d    = ga_q;
    gb_d    = gb_q;
    valid_d = valid_q;
    u0_d    = u0_q;
    u1_d    = u1_q;
    case (state_q)
      IDLE: begin
        if (seed_we) begin
          case (seed_sel)
            3'd0: ga_d[31:0]  = seed_fix(2'd0, seed_data);
            3'd1: ga_d[63:32] = seed_fix(2'd1, seed_data);
            3'd2: ga_d[95:64] = seed_fix(2'd2, seed_data);
            3'd3: gb_d[31:0]  = seed_fix(2'd0, seed_data);
            3'd4: gb_d[63:32] = seed_fix(2'd1, seed_data);
            3'd5: gb_d[95:64] = seed_fix(2'd2, seed_data);
            default: ;
          endcase
        end
        if (start && !stop) begin
          cnt_d   = CW'(WARMUP);
          state_d = (WARMUP == 0) ? RUN : WARM;
        end
      end
      WARM: begin
        if (stop) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else begin
          ga_d  = ga_n;
          gb_d  = gb_n;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else if (!valid_q || out_ready) begin
          ga_d    = ga_n;
          gb_d    = gb_n;
          u0_d    = {wa, wb[31:16]};
          u1_d    = wb[15:0];
          valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ga_q    <= A_RST;
      gb_q    <= B_RST;
      valid_q <= 1'b0;
      u0_q    <= '0;
      u1_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ga_q    <= ga_d;
      gb_q    <= gb_d;
      valid_q <= valid_d;
      u0_q    <= u0_d;
      u1_q    <= u1_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = valid_q;
  assign u0        = u0_q;
  assign u1        = u1_q;

endmodule

`default_nettype wire

// File: tb/tb_urng_taus_pair.sv
// Bench for urng_taus_pair: directed phases checked against a taus88 reference
// model through an expected-sample queue.
`default_nettype none

module tb_urng_taus_pair;

  logic        clk;
  logic        rst_n;
  logic        seed_we;
  logic [2:0]  seed_sel;
  logic [31:0] seed_data;
  logic        start0, start1, stop, out_ready;
  logic        busy0, busy1, ov0, ov1;
  logic [47:0] u0_0, u0_1;
  logic [15:0] u1_0, u1_1;

  urng_taus_pair #(.WARMUP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .seed_we(seed_we), .seed_sel(seed_sel),
    .seed_data(seed_data), .start(start0), .stop(stop), .busy(busy0),
    .out_valid(ov0), .out_ready(out_ready), .u0(u0_0), .u1(u1_0)
  );

  urng_taus_pair #(.WARMUP(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .seed_we(seed_we), .seed_sel(seed_sel),
    .seed_data(seed_data), .start(start1), .stop(stop), .busy(busy1),
    .out_valid(ov1), .out_ready(out_ready), .u0(u0_1), .u1(u1_1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  bit          which;
  logic        s_valid, s_busy;
  logic [63:0] s_u;
  always_comb begin
    s_valid = which ? ov1 : ov0;
    s_busy  = which ? busy1 : busy0;
    s_u     = which ? {u0_1, u1_1} : {u0_0, u1_0};
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference model state and expected-sample queue ({u0,u1} == {A word, B word}).
  logic [31:0] a1, a2, a3, b1, b2, b3;
  logic [63:0] q[$];

  task automatic taus(inout logic [31:0] x1, inout logic [31:0] x2,
                      inout logic [31:0] x3, output logic [31:0] w);
    logic [31:0] t;
    t  = ((x1 << 13) ^ x1) >> 19;
    x1 = ((x1 & 32'hFFFF_FFFE) << 12) ^ t;
    t  = ((x2 << 2) ^ x2) >> 25;
    x2 = ((x2 & 32'hFFFF_FFF8) << 4) ^ t;
    t  = ((x3 << 3) ^ x3) >> 11;
    x3 = ((x3 & 32'hFFFF_FFF0) << 17) ^ t;
    w  = x1 ^ x2 ^ x3;
  endtask

  task automatic model_next();
    logic [31:0] wa, wb;
    taus(a1, a2, a3, wa);
    taus(b1, b2, b3, wb);
    q.push_back({wa, wb});
  endtask

  task automatic model_skip(input int n);
    repeat (n) begin
      model_next();
      void'(q.pop_back());
    end
  endtask

  task automatic model_reset();
    a1 = 32'h0000_3039; a2 = 32'h0001_0932; a3 = 32'h0000_D431;
    b1 = 32'h1234_5678; b2 = 32'h9ABC_DEF0; b3 = 32'h0F1E_2D3C;
    q.delete();
  endtask

  function automatic logic [31:0] lift(input logic [31:0] d, input logic [31:0] m);
    return (d < m) ? d + m : d;
  endfunction

  task automatic model_seed(input int sel, input logic [31:0] d);
    case (sel)
      0: a1 = lift(d, 2);
      1: a2 = lift(d, 8);
      2: a3 = lift(d, 16);
      3: b1 = lift(d, 2);
      4: b2 = lift(d, 8);
      5: b3 = lift(d, 16);
      default: ;
    endcase
  endtask

  task automatic seed_write(input int sel, input logic [31:0] d);
    @(negedge clk);
    seed_we = 1'b1; seed_sel = 3'(sel); seed_data = d;
    @(negedge clk);
    seed_we = 1'b0;
  endtask

  task automatic pulse_start1();
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
  endtask

  // Randomised-ready consumer: every valid cycle must show the head of the queue.
  task automatic accept(input int n, input int pct);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < n * 40 + 100) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(0, 99) < pct);
      if (s_valid) begin
        if (q.size() == 0) model_next();
        check("sample", s_u, q[0]);
        if (out_ready) begin
          void'(q.pop_front());
          got++;
        end
      end
    end
    check("accept_count", 64'(got), 64'(n));
  endtask

  // Stop with the pending sample left unconsumed; it is dropped from the model too.
  task automatic do_stop();
    @(negedge clk);
    out_ready = 1'b0;
    if (s_valid) begin
      if (q.size() == 0) model_next();
      check("pending_before_stop", s_u, q[0]);
      void'(q.pop_front());
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("busy_after_stop", 64'(s_busy), 64'd0);
    check("valid_after_stop", 64'(s_valid), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; seed_we = 1'b0; seed_sel = '0; seed_data = '0;
    start0 = 1'b0; start1 = 1'b0; stop = 1'b0; out_ready = 1'b0;
    which = 1'b0;
    #3;
    check("rst_valid0", 64'(ov0), 64'd0);
    check("rst_u_0", {u0_0, u1_0}, 64'd0);
    check("rst_busy0", 64'(busy0), 64'd0);
    check("rst_valid1", 64'(ov1), 64'd0);
    check("rst_busy1", 64'(busy1), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Default seeds, no warm-up, full-rate consumer.
    which = 1'b0;
    model_reset();
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check("w0_busy_run", 64'(busy0), 64'd1);
    check("w0_valid_at_run_entry", 64'(ov0), 64'd0);
    @(negedge clk);
    check("w0_first_valid", 64'(ov0), 64'd1);
    model_next();
    check("w0_first_sample", s_u, q[0]);
    accept(1000, 100);
    do_stop();

    // Loaded seeds with a 16-step warm-up.
    which = 1'b1;
    model_reset();
    seed_write(0, 32'd12345); model_seed(0, 32'd12345);
    seed_write(1, 32'd67890); model_seed(1, 32'd67890);
    seed_write(2, 32'd13579); model_seed(2, 32'd13579);
    seed_write(3, 32'd24680); model_seed(3, 32'd24680);
    seed_write(4, 32'd11111); model_seed(4, 32'd11111);
    seed_write(5, 32'd99999); model_seed(5, 32'd99999);
    pulse_start1();
    model_skip(16);
    check("warm_busy", 64'(busy1), 64'd1);
    check("warm_valid", 64'(ov1), 64'd0);
    repeat (15) begin
      @(negedge clk);
      check("warm_valid", 64'(ov1), 64'd0);
    end
    accept(1, 100);
    do_stop();

    // Below-minimum seeds, then long random-backpressure run.
    seed_write(0, 32'd1); model_seed(0, 32'd1);
    seed_write(1, 32'd5); model_seed(1, 32'd5);
    seed_write(5, 32'd0); model_seed(5, 32'd0);
    pulse_start1();
    model_skip(16);
    accept(20, 100);
    accept(5000, 30);

    // Seed writes while running are ignored.
    @(negedge clk);
    out_ready = 1'b0;
    if (s_valid && q.size() == 0) model_next();
    seed_write(0, 32'hDEAD_BEEF);
    seed_write(4, 32'h0);
    accept(50, 50);

    // Stop with a pending sample, ignored sel 6/7 writes, then restart.
    do_stop();
    seed_write(7, 32'h0);
    seed_write(6, 32'h1);
    pulse_start1();
    model_skip(16);
    accept(30, 60);

    // Asynchronous reset between clock edges while running.
    @(negedge clk);
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(ov1), 64'd0);
    check("async_rst_u", {u0_1, u1_1}, 64'd0);
    check("async_rst_busy", 64'(busy1), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b0;
    model_reset();
    pulse_start1();
    model_skip(16);
    accept(20, 100);
    do_stop();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
